// File: rtl/req_event_encoder_pkg.sv
// Shared widths and helpers for the request event encoder path.
package req_event_encoder_pkg;

  localparam int unsigned REQ_W  = 4;
  localparam int unsigned CODE_W = 2;

  function automatic logic [REQ_W-1:0] code2onehot(input logic [CODE_W-1:0] code);
    return REQ_W'(1) << code;
  endfunction

endpackage

// File: rtl/req_event_encoder_prio_idx4.sv
// Fixed-priority lowest-set-bit encoder: bit 0 wins, plus an any-set flag.
module prio_idx4
  import req_event_encoder_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = |vec;
    casez (vec)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/req_event_encoder.sv
// Captures request events into sticky pending bits and issues one encoded
// index per event over a valid/ready slot, highest priority first.
module req_event_encoder
  import req_event_encoder_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_W-1:0]  req,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [REQ_W-1:0]  pending,
  output logic              busy
);

  logic [REQ_W-1:0]  req_q;
  logic [REQ_W-1:0]  ev;
  logic [REQ_W-1:0]  ld_mask;
  logic [CODE_W-1:0] idx;
  logic              any;
  logic              slot_free;
  logic              ld;
  logic              lost;

  prio_idx4 u_prio (
    .vec (pending),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    ev        = EDGE_MODE ? (req & ~req_q) : req;
    slot_free = !out_valid || out_ready;
    ld        = slot_free && any;
    ld_mask   = ld ? code2onehot(idx) : '0;
    // An event landing on a bit that is being loaded this cycle is a new event, not a loss.
    lost      = |(ev & pending & ~ld_mask);
    busy      = (|pending) || out_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      ovf       <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~ld_mask) | ev;
      if (ld) begin
        out_code  <= idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (lost)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_event_encoder.sv
// Randomized and directed bench for req_event_encoder in edge and level modes.
module tb_req_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic       ovf_clr;

  logic [1:0] e_code, l_code;
  logic       e_valid, l_valid, e_ovf, l_ovf, e_busy, l_busy;
  logic [3:0] e_pend, l_pend;

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = level mode, 1 = edge mode.
  logic [3:0] m_prev[2];
  logic [3:0] m_pend[2];
  logic       m_valid[2];
  int         m_code[2];
  logic       m_ovf[2];

  always #5 clk = ~clk;

  req_event_encoder #(.EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .rst_n(rst_n), .req(req), .out_code(e_code), .out_valid(e_valid),
    .out_ready(out_ready), .ovf(e_ovf), .ovf_clr(ovf_clr), .pending(e_pend), .busy(e_busy)
  );

  req_event_encoder #(.EDGE_MODE(1'b0)) u_level (
    .clk(clk), .rst_n(rst_n), .req(req), .out_code(l_code), .out_valid(l_valid),
    .out_ready(out_ready), .ovf(l_ovf), .ovf_clr(ovf_clr), .pending(l_pend), .busy(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int m);
    bit   found;
    bit   free;
    bit   lost;
    logic [3:0] ev;
    logic [3:0] taken;
    if (!rst_n) begin
      m_prev[m] = '0; m_pend[m] = '0; m_valid[m] = 1'b0; m_code[m] = 0; m_ovf[m] = 1'b0;
      return;
    end
    ev = '0; taken = '0; found = 0; lost = 0;
    for (int i = 0; i < 4; i++)
      ev[i] = (m == 1) ? (req[i] && !m_prev[m][i]) : req[i];
    free = !m_valid[m] || out_ready;
    if (free)
      for (int i = 0; i < 4; i++)
        if (!found && m_pend[m][i]) begin
          found = 1; m_code[m] = i; taken[i] = 1'b1;
        end
    if (found) m_valid[m] = 1'b1;
    else if (out_ready) m_valid[m] = 1'b0;
    for (int i = 0; i < 4; i++)
      if (ev[i] && m_pend[m][i] && !taken[i]) lost = 1;
    if (lost) m_ovf[m] = 1'b1;
    else if (ovf_clr) m_ovf[m] = 1'b0;
    for (int i = 0; i < 4; i++)
      m_pend[m][i] = (m_pend[m][i] && !taken[i]) || ev[i];
    m_prev[m] = req;
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic rdy, input logic clr);
    @(negedge clk);
    rst_n = r; req = rq; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("e_valid", 32'(e_valid), 32'(m_valid[1]));
    check("e_code",  32'(e_code),  32'(m_code[1]));
    check("e_pend",  32'(e_pend),  32'(m_pend[1]));
    check("e_ovf",   32'(e_ovf),   32'(m_ovf[1]));
    check("e_busy",  32'(e_busy),  32'((|m_pend[1]) || m_valid[1]));
    check("l_valid", 32'(l_valid), 32'(m_valid[0]));
    check("l_code",  32'(l_code),  32'(m_code[0]));
    check("l_pend",  32'(l_pend),  32'(m_pend[0]));
    check("l_ovf",   32'(l_ovf),   32'(m_ovf[0]));
    check("l_busy",  32'(l_busy),  32'((|m_pend[0]) || m_valid[0]));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) cyc(1'b0, 4'b0000, 1'b1, 1'b0);
    // Single pulse on line 2, then accept.
    cyc(1'b1, 4'b0100, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    // Three lines at once, back-to-back drain.
    cyc(1'b1, 4'b1011, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    // Stalled slot holds its code.
    cyc(1'b1, 4'b0110, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    // Lost event on a waiting bit, then clear.
    cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    // New event on the bit being loaded is kept without overflow.
    cyc(1'b1, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0010, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    // Line 0 held high, then reset mid-stream.
    repeat (6) cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    cyc(1'b0, 4'b0001, 1'b1, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0);
    // Random traffic with varying density and backpressure.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] rq;
      rq = 4'($urandom);
      if (n < 1500) rq = rq & 4'($urandom) & 4'($urandom);
      cyc($urandom_range(0, 99) != 0, rq, $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0);
    end
    repeat (8) cyc(1'b1, 4'b0000, 1'b1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
